// File: rtl/mod_issue_ctrl.sv
// mod_issue_ctrl
// In-order issue controller between decode/register-read and mod_execute.
// Tracks a per-register scoreboard, holds back RAW/WAW hazards, sequences
// multi-cycle ops, serializing ops and conditional branches, and generates
// the can_execute pulse that starts the execute stage.
//
// Optional feature macro: ISSUE_BYPASS_EN
//   defined   : a register being cleared by writeback this cycle is treated
//               as not busy for the hazard and drain checks.
//   undefined : hazard and drain checks use the registered scoreboard only.
//
// Ports
//   clk_i, reset_i            clock, async active-high reset
//   dec_valid_i / dec_ready_o decode handshake (dec_ready_o is combinational)
//   dec_src_{a,b}_i(_vld_i)   source registers and their use flags
//   dec_dst_i, dec_dst2_i     destination registers (dst2 = RDX for IMUL)
//   dec_dst_vld_i, dec_dst2_vld_i
//   dec_class_i               0 single, 1 multi-cycle, 2 serializing, 3 branch
//   ex_ready_i                execute stage can accept an op
//   wb_clr*_vld_i/_reg_i      two writeback retire ports
//   br_resolved_i, flush_i    branch not-taken / taken resolution
//   can_execute_o             registered one-cycle issue pulse
//   ex_busy_o                 controller is not IDLE
//   busy_vec_o                scoreboard
//   stall_cycles_o            saturating count of dec_valid & !dec_ready cycles
//
// State    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | accepting ops, issues when ready
// S_MULTI  | multi-cycle op occupying execute, counter running down
// S_SERIAL | serializing op waiting for the scoreboard to drain
// S_BRANCH | branch issued, younger ops held until it resolves
module mod_issue_ctrl #(
  parameter int NREGS   = 16,
  parameter int MUL_LAT = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             dec_valid_i,
  output logic             dec_ready_o,
  input  logic [3:0]       dec_src_a_i,
  input  logic [3:0]       dec_src_b_i,
  input  logic             dec_src_a_vld_i,
  input  logic             dec_src_b_vld_i,
  input  logic [3:0]       dec_dst_i,
  input  logic [3:0]       dec_dst2_i,
  input  logic             dec_dst_vld_i,
  input  logic             dec_dst2_vld_i,
  input  logic [1:0]       dec_class_i,
  input  logic             ex_ready_i,
  input  logic             wb_clr_vld_i,
  input  logic             wb_clr2_vld_i,
  input  logic [3:0]       wb_clr_reg_i,
  input  logic [3:0]       wb_clr2_reg_i,
  input  logic             br_resolved_i,
  input  logic             flush_i,
  output logic             can_execute_o,
  output logic             ex_busy_o,
  output logic [NREGS-1:0] busy_vec_o,
  output logic [31:0]      stall_cycles_o
);

  typedef enum logic [1:0] {S_IDLE, S_MULTI, S_SERIAL, S_BRANCH} state_e;

  localparam logic [1:0] CLS_MULTI  = 2'd1;
  localparam logic [1:0] CLS_SERIAL = 2'd2;
  localparam logic [1:0] CLS_BRANCH = 2'd3;
  localparam logic [3:0] CNT_INIT   = 4'(MUL_LAT - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic             can_exec_q, can_exec_d;
  logic [31:0]      stall_q, stall_d;

  logic [NREGS-1:0] clr_mask, set_mask, busy_eff;
  logic             hazard, drained, issue;

  always_comb begin
    clr_mask = '0;
    if (wb_clr_vld_i)  clr_mask[wb_clr_reg_i]  = 1'b1;
    if (wb_clr2_vld_i) clr_mask[wb_clr2_reg_i] = 1'b1;
  end

`ifdef ISSUE_BYPASS_EN
  assign busy_eff = busy_q & ~clr_mask;
`else
  assign busy_eff = busy_q;
`endif

  assign hazard  = (dec_src_a_vld_i & busy_eff[dec_src_a_i]) |
                   (dec_src_b_vld_i & busy_eff[dec_src_b_i]) |
                   (dec_dst_vld_i   & busy_eff[dec_dst_i])   |
                   (dec_dst2_vld_i  & busy_eff[dec_dst2_i]);
  assign drained = (busy_eff == '0);

  assign dec_ready_o = (state_q == S_IDLE) & ex_ready_i & ~hazard &
                       ((dec_class_i != CLS_SERIAL) | drained);
  assign issue       = dec_valid_i & dec_ready_o;

  always_comb begin
    set_mask = '0;
    if (issue & dec_dst_vld_i)  set_mask[dec_dst_i]  = 1'b1;
    if (issue & dec_dst2_vld_i) set_mask[dec_dst2_i] = 1'b1;
    // Set after clear so a new producer wins over a same-cycle retire.
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    can_exec_d = issue;
    stall_d    = stall_q;
    if (dec_valid_i & ~dec_ready_o & (stall_q != '1)) stall_d = stall_q + 32'd1;

    unique case (state_q)
      S_IDLE: begin
        if (issue) begin
          if (dec_class_i == CLS_MULTI) begin
            state_d = S_MULTI;
            cnt_d   = CNT_INIT;
          end else if (dec_class_i == CLS_BRANCH) begin
            state_d = S_BRANCH;
          end
        end else if (dec_valid_i & (dec_class_i == CLS_SERIAL) & (hazard | ~drained)) begin
          state_d = S_SERIAL;
        end
      end
      S_MULTI: begin
        // Older than any branch in flight, so flush does not cut it short.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_SERIAL: begin
        if (drained) state_d = S_IDLE;
      end
      S_BRANCH: begin
        if (br_resolved_i | flush_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy_q     <= '0;
      can_exec_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      can_exec_q <= can_exec_d;
      stall_q    <= stall_d;
    end
  end

  assign can_execute_o  = can_exec_q;
  assign ex_busy_o      = (state_q != S_IDLE);
  assign busy_vec_o     = busy_q;
  assign stall_cycles_o = stall_q;

endmodule
